branch_exec_unit: RTL and testbench
===================================

Name: branch_exec_unit

Overview:
- Execution stage directly downstream of the branch reservation station.
- Takes one issued branch/jump per cycle, resolves it (direction, target, link value) and buffers the result in a small FIFO.
- Drives the branch CDB port under an arbiter grant handshake.
- The ROB consumes taken/target to detect mispredicts. Stall output throttles issue from the reservation station.

Parameters:
- DATA_W, 32, width of operands, imm, pc, CDB data.
- TAG_W, 4, ROB tag width.
- OP_W, 6, opcode width (cpu_define op encodings: BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR).
- DEPTH, 2, result FIFO entries; power of two, at least 2.

Ports:
- clk in 1 clock.
- rst in 1 reset; synchronous, active-high.
- rdy in 1 global enable; when low, all state holds.
- clear in 1 pipeline flush (mispredict).
- in_valid in 1 issued instruction valid.
- in_op in OP_W opcode.
- in_reg1 in DATA_W rs1 value.
- in_reg2 in DATA_W rs2 value.
- in_imm in DATA_W sign-extended immediate.
- in_pc in DATA_W instruction pc.
- in_tag in TAG_W destination ROB tag.
- stall out 1 issue throttle to the RS.
- cdb_valid out 1 result available.
- cdb_tag out TAG_W ROB tag.
- cdb_data out DATA_W link value.
- cdb_taken out 1 resolved direction.
- cdb_target out DATA_W resolved next pc.
- cdb_grant in 1 arbiter accepted the current result.
- overflow out 1 sticky: result dropped.

Behaviour:
- Reset (rst, sync):
  - FIFO empty; cdb_valid=0; cdb_tag/data/target=0; cdb_taken=0; overflow=0; stall=0.
  - Reset wins over clear and rdy.
- rdy low: no enqueue, no dequeue, no flag update. Outputs hold.
- Resolution (combinational on inputs, registered into FIFO):
  - BEQ: taken = reg1==reg2. BNE: !=.
  - BLT/BGE: signed < / >=. BLTU/BGEU: unsigned < / >=.
  - JAL and JALR: always taken.
  - target = pc+imm when taken (branches, JAL); JALR target = (reg1+imm) with bit0 cleared; not-taken target = pc+4.
  - data = pc+4 for JAL/JALR, else 0.
  - All adds are DATA_W, modulo 2^DATA_W (wrap ignored).
  - Unknown op: taken=0, target=pc+4, data=0; still enqueued.
- Latency: in_valid sampled at edge N (rdy=1) appears on cdb_* after edge N when the FIFO was empty. Minimum 1 cycle.
- FIFO:
  - cdb_* always reflects the head entry; cdb_valid = count!=0.
  - Dequeue when rdy && cdb_valid && cdb_grant. cdb_grant with cdb_valid=0 is ignored.
  - Enqueue when rdy && in_valid && !clear.
  - Enqueue and dequeue in the same cycle are both performed; count unchanged, also when full.
  - Full, no dequeue, in_valid: entry dropped, overflow<=1 (sticky until rst).
  - Pointers wrap modulo DEPTH; count is 0..DEPTH.
- stall = (count >= DEPTH-1), combinational. Covers the one instruction already in flight from the registered RS output.
- clear (rdy=1):
  - Next cycle count=0, cdb_valid=0.
  - Same-cycle in_valid is discarded; same-cycle grant is irrelevant.
  - overflow unaffected.
- clear with rdy=0: ignored.

Test Plan:
- BEQ, reg1=reg2=5, pc=0x100, imm=0x20, tag=3, grant=1 → next cycle cdb_valid=1, tag=3, taken=1, target=0x120, data=0. Following cycle cdb_valid=0.
- BLT reg1=0xFFFFFFFF, reg2=1 → taken=1. BLTU same operands → taken=0, target=pc+4.
- JALR reg1=0x1003, imm=4, pc=0x200 → target=0x1006, data=0x204, taken=1.
- grant=0, three back-to-back issues (DEPTH=2):
  - stall=1 once count=1.
  - Third result dropped, overflow=1.
  - Then grant=1 drains tags 1,2 in order over two cycles.
- FIFO full, in_valid with grant=1 same cycle → count stays 2, head advances, new entry at tail.
- FIFO holding 2 entries, clear=1 with in_valid=1 → next cycle cdb_valid=0, stall=0. rdy=0 for 3 cycles before clear holds all outputs unchanged.

Source files
------------

// File: rtl/branch_exec_unit.sv
// Branch/jump execution stage: resolves direction, target and link value for one
// issued instruction per cycle and buffers results in a small FIFO feeding the CDB.
module branch_exec_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [DATA_W-1:0] in_reg2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              stall,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_taken,
  output logic [DATA_W-1:0] cdb_target,
  input  logic              cdb_grant,
  output logic              overflow
);

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(8);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              taken;
    logic [DATA_W-1:0] target;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [DATA_W-1:0]  pc4, br_target, jalr_target;
  entry_t             res;
  logic               full, do_deq, do_enq, do_drop;

  always_comb begin
    pc4         = in_pc + DATA_W'(4);
    br_target   = in_pc + in_imm;
    jalr_target = (in_reg1 + in_imm) & ~DATA_W'(1);
    res         = '0;
    res.tag     = in_tag;
    res.target  = pc4;
    case (in_op)
      OP_BEQ:  res.taken = (in_reg1 == in_reg2);
      OP_BNE:  res.taken = (in_reg1 != in_reg2);
      OP_BLT:  res.taken = ($signed(in_reg1) <  $signed(in_reg2));
      OP_BGE:  res.taken = ($signed(in_reg1) >= $signed(in_reg2));
      OP_BLTU: res.taken = (in_reg1 <  in_reg2);
      OP_BGEU: res.taken = (in_reg1 >= in_reg2);
      OP_JAL, OP_JALR: begin
        res.taken = 1'b1;
        res.data  = pc4;
      end
      default: res.taken = 1'b0;
    endcase
    if (in_op == OP_JALR)
      res.target = jalr_target;
    else if (res.taken)
      res.target = br_target;
  end

  // A dequeue frees the head slot first, so a full FIFO can still accept in the same cycle.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_deq   = rdy && !clear && (count_q != '0) && cdb_grant;
    do_enq   = rdy && !clear && in_valid && (!full || do_deq);
    do_drop  = rdy && !clear && in_valid && full && !do_deq;

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || do_drop;

    if (do_enq) begin
      mem_d[wr_ptr_q] = res;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_deq)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_enq && !do_deq)
      count_d = count_q + CNT_W'(1);
    else if (do_deq && !do_enq)
      count_d = count_q - CNT_W'(1);

    if (rdy && clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    stall      = (count_q >= CNT_W'(DEPTH - 1));
    cdb_valid  = (count_q != '0);
    cdb_tag    = mem_q[rd_ptr_q].tag;
    cdb_data   = mem_q[rd_ptr_q].data;
    cdb_taken  = mem_q[rd_ptr_q].taken;
    cdb_target = mem_q[rd_ptr_q].target;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed bench for branch_exec_unit: a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_branch_exec_unit;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 6;
  localparam int DEPTH  = 2;

  localparam logic [OP_W-1:0] BEQ  = 6'd1;
  localparam logic [OP_W-1:0] BNE  = 6'd2;
  localparam logic [OP_W-1:0] BLT  = 6'd3;
  localparam logic [OP_W-1:0] BGE  = 6'd4;
  localparam logic [OP_W-1:0] BLTU = 6'd5;
  localparam logic [OP_W-1:0] BGEU = 6'd6;
  localparam logic [OP_W-1:0] JAL  = 6'd7;
  localparam logic [OP_W-1:0] JALR = 6'd8;
  localparam logic [OP_W-1:0] BAD  = 6'd0;

  logic              clk = 1'b0;
  logic              rst, rdy, clear, in_valid, cdb_grant;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_reg1, in_reg2, in_imm, in_pc;
  logic [TAG_W-1:0]  in_tag;
  logic              stall, cdb_valid, cdb_taken, overflow;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data, cdb_target;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              taken;
    logic [DATA_W-1:0] target;
  } res_t;

  res_t model_q[$];
  logic model_ovf = 1'b0;
  logic model_ready = 1'b0;

  branch_exec_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
    .stall(stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target), .cdb_grant(cdb_grant),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t resolve(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] r1,
                                   input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] imm,
                                   input logic [DATA_W-1:0] pc, input logic [TAG_W-1:0] tag);
    res_t r;
    longint s1, s2;
    s1 = longint'($signed(r1));
    s2 = longint'($signed(r2));
    r.tag = tag;
    r.data = 0;
    case (op)
      BEQ:  r.taken = (r1 == r2);
      BNE:  r.taken = (r1 != r2);
      BLT:  r.taken = (s1 < s2);
      BGE:  r.taken = (s1 >= s2);
      BLTU: r.taken = (r1 < r2);
      BGEU: r.taken = (r1 >= r2);
      JAL, JALR: r.taken = 1'b1;
      default: r.taken = 1'b0;
    endcase
    if (op == JAL || op == JALR) r.data = pc + 4;
    if (op == JALR)      r.target = ((r1 + imm) >> 1) << 1;
    else if (r.taken)    r.target = pc + imm;
    else                 r.target = pc + 4;
    return r;
  endfunction

  // Reference model: advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_ready = 1'b1;
    end else if (rdy) begin
      if (clear) model_q.delete();
      else begin
        if (model_q.size() != 0 && cdb_grant) void'(model_q.pop_front());
        if (in_valid) begin
          if (model_q.size() < DEPTH)
            model_q.push_back(resolve(in_op, in_reg1, in_reg2, in_imm, in_pc, in_tag));
          else
            model_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check_output("model_valid", cdb_valid, model_q.size() != 0);
      check_output("model_stall", stall, model_q.size() >= DEPTH - 1);
      check_output("model_overflow", overflow, model_ovf);
      if (model_q.size() != 0) begin
        check_output("model_tag", cdb_tag, model_q[0].tag);
        check_output("model_taken", cdb_taken, model_q[0].taken);
        check_output("model_target", cdb_target, model_q[0].target);
        check_output("model_data", cdb_data, model_q[0].data);
      end
    end
  end

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic apply_stimulus(input logic v, input logic [OP_W-1:0] op,
                                input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                                input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc,
                                input logic [TAG_W-1:0] tag, input logic grant,
                                input logic clr = 1'b0, input logic en = 1'b1);
    in_valid = v; in_op = op; in_reg1 = r1; in_reg2 = r2; in_imm = imm;
    in_pc = pc; in_tag = tag; cdb_grant = grant; clear = clr; rdy = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic grant);
    apply_stimulus(1'b0, BAD, 0, 0, 0, 0, 0, grant);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
    in_op = BAD; in_reg1 = 0; in_reg2 = 0; in_imm = 0; in_pc = 0; in_tag = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_valid", cdb_valid, 0);
    check_output("rst_tag", cdb_tag, 0);
    check_output("rst_data", cdb_data, 0);
    check_output("rst_target", cdb_target, 0);
    check_output("rst_taken", cdb_taken, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_stall", stall, 0);
    rst = 1'b0;

    apply_stimulus(1, BEQ, 5, 5, 32'h20, 32'h100, 3, 1);
    check_output("beq_valid", cdb_valid, 1);
    check_output("beq_tag", cdb_tag, 3);
    check_output("beq_taken", cdb_taken, 1);
    check_output("beq_target", cdb_target, 32'h120);
    check_output("beq_data", cdb_data, 0);
    idle(1);
    check_output("beq_drained", cdb_valid, 0);

    apply_stimulus(1, BLT, 32'hFFFF_FFFF, 1, 32'h10, 32'h300, 4, 1);
    check_output("blt_taken", cdb_taken, 1);
    check_output("blt_target", cdb_target, 32'h310);
    apply_stimulus(1, BLTU, 32'hFFFF_FFFF, 1, 32'h10, 32'h300, 5, 1);
    check_output("bltu_tag", cdb_tag, 5);
    check_output("bltu_taken", cdb_taken, 0);
    check_output("bltu_target", cdb_target, 32'h304);
    apply_stimulus(1, BGE, 32'h8000_0000, 0, 32'h40, 32'h600, 6, 1);
    check_output("bge_taken", cdb_taken, 0);
    apply_stimulus(1, BGEU, 32'h8000_0000, 0, 32'h40, 32'h600, 7, 1);
    check_output("bgeu_target", cdb_target, 32'h640);

    apply_stimulus(1, JALR, 32'h1003, 0, 4, 32'h200, 6, 1);
    check_output("jalr_target", cdb_target, 32'h1006);
    check_output("jalr_data", cdb_data, 32'h204);
    check_output("jalr_taken", cdb_taken, 1);
    apply_stimulus(1, JAL, 0, 0, 32'hFFFF_FFF8, 32'h500, 9, 1);
    check_output("jal_target", cdb_target, 32'h4F8);
    check_output("jal_data", cdb_data, 32'h504);
    apply_stimulus(1, BAD, 1, 1, 32'h80, 32'h400, 13, 1);
    check_output("unk_taken", cdb_taken, 0);
    check_output("unk_target", cdb_target, 32'h404);
    idle(1);

    apply_stimulus(1, BNE, 1, 2, 8, 32'h700, 1, 0);
    check_output("ovf_stall1", stall, 1);
    apply_stimulus(1, BNE, 1, 1, 8, 32'h704, 2, 0);
    apply_stimulus(1, BEQ, 1, 1, 8, 32'h708, 7, 0);
    check_output("ovf_flag", overflow, 1);
    check_output("ovf_head", cdb_tag, 1);
    idle(1);
    check_output("drain_head2", cdb_tag, 2);
    idle(1);
    check_output("drain_empty", cdb_valid, 0);

    apply_stimulus(1, BEQ, 0, 0, 4, 32'h800, 8, 0);
    apply_stimulus(1, BEQ, 0, 1, 4, 32'h810, 9, 0);
    apply_stimulus(1, BEQ, 0, 0, 4, 32'h820, 10, 1);
    check_output("fullx_head", cdb_tag, 9);
    check_output("fullx_stall", stall, 1);
    idle(1);
    check_output("fullx_tail", cdb_tag, 10);
    check_output("fullx_target", cdb_target, 32'h824);
    idle(1);

    apply_stimulus(1, BEQ, 0, 0, 4, 32'h900, 11, 0);
    apply_stimulus(1, BEQ, 0, 0, 4, 32'h904, 12, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, BEQ, 0, 0, 4, 32'h908, 14, 1, 1, 0);
      check_output("hold_tag", cdb_tag, 11);
      check_output("hold_valid", cdb_valid, 1);
    end
    apply_stimulus(1, BEQ, 0, 0, 4, 32'h90C, 15, 1, 1, 1);
    check_output("clear_valid", cdb_valid, 0);
    check_output("clear_stall", stall, 0);
    check_output("clear_overflow", overflow, 1);
    idle(0);

    rst = 1'b1;
    idle(0);
    rst = 1'b0;
    check_output("rerst_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
